bcd_entry: RTL

Decimal keyboard-entry front end for the lab calculator: the input-side counterpart of the binary→BCD→7-segment display path. The operator sets one decimal digit on four switches and pushes it in with a key; a sign key toggles negative, and a done key converts the entered three-digit signed decimal number into a signed 9-bit two's-complement value. The result feeds the adder's A/B operand registers. The entered BCD digits and sign are echoed out so the existing display path can show them while typing.

---
 rtl/bcd_entry.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_entry.sv
// Decimal keypad front end: debounces four keys, collects up to three BCD digits and a sign,
// then converts the entry to a signed 9-bit two's-complement value.
module bcd_entry #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        digit_in,
    input  logic              key_enter,
    input  logic              key_sign,
    input  logic              key_done,
    input  logic              key_clear,
    output logic [3:0]        bcd2,
    output logic [3:0]        bcd1,
    output logic [3:0]        bcd0,
    output logic              neg,
    output logic signed [8:0] bin_out,
    output logic              valid,
    output logic              ovf,
    output logic              err_digit,
    output logic              busy
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        ENTRY,
        CONV,
        DONE
    } state_t;

    // Key vector order: [0] enter, [1] sign, [2] done, [3] clear
    logic [3:0]    key_raw;
    logic [3:0]    key_s1;
    logic [3:0]    key_s2;
    logic [3:0]    key_deb;
    logic [3:0]    key_deb_d;
    logic [3:0]    key_ev;
    logic [CW-1:0] deb_cnt [4];

    logic [3:0]    dig_s1;
    logic [3:0]    dig_s2;

    state_t        state;
    logic [1:0]    conv_step;
    logic [9:0]    acc;
    logic [3:0]    mac_digit;
    logic [9:0]    acc_mac;

    logic          ev_clear;
    logic          ev_done;
    logic          ev_enter;
    logic          ev_sign;

    assign key_raw = {key_clear, key_done, key_sign, key_enter};

    // The event is taken from a registered copy of the debounced level, so it lands one cycle after the flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= '0;
            key_s2    <= '0;
            key_deb   <= '0;
            key_deb_d <= '0;
            key_ev    <= '0;
            dig_s1    <= '0;
            dig_s2    <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            key_s1    <= key_raw;
            key_s2    <= key_s1;
            key_deb_d <= key_deb;
            key_ev    <= key_deb & ~key_deb_d;
            dig_s1    <= digit_in;
            dig_s2    <= dig_s1;
            for (int i = 0; i < 4; i++) begin
                if (key_s2[i] == key_deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == CNT_LAST) begin
                    key_deb[i] <= key_s2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Only the highest-priority event of a cycle acts: clear > done > enter > sign.
    assign ev_clear = key_ev[3];
    assign ev_done  = key_ev[2] & ~key_ev[3];
    assign ev_enter = key_ev[0] & ~key_ev[3] & ~key_ev[2];
    assign ev_sign  = key_ev[1] & ~key_ev[3] & ~key_ev[2] & ~key_ev[0];

    assign mac_digit = (conv_step == 2'd1) ? bcd1 : bcd0;
    assign acc_mac   = (acc * 10'd10) + {6'd0, mac_digit};

    // The last CONV step writes the result registers directly so valid appears in the DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ENTRY;
            conv_step <= 2'd0;
            acc       <= '0;
            bcd2      <= '0;
            bcd1      <= '0;
            bcd0      <= '0;
            neg       <= 1'b0;
            bin_out   <= '0;
            valid     <= 1'b0;
            ovf       <= 1'b0;
            err_digit <= 1'b0;
            busy      <= 1'b0;
        end else begin
            valid     <= 1'b0;
            err_digit <= 1'b0;
            if (ev_clear) begin
                state     <= ENTRY;
                conv_step <= 2'd0;
                bcd2      <= '0;
                bcd1      <= '0;
                bcd0      <= '0;
                neg       <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    ENTRY: begin
                        if (ev_done) begin
                            state     <= CONV;
                            conv_step <= 2'd0;
                            busy      <= 1'b1;
                        end else if (ev_enter) begin
                            if (dig_s2 > 4'd9) begin
                                err_digit <= 1'b1;
                            end else begin
                                bcd2 <= bcd1;
                                bcd1 <= bcd0;
                                bcd0 <= dig_s2;
                            end
                        end else if (ev_sign) begin
                            neg <= ~neg;
                        end
                    end
                    CONV: begin
                        case (conv_step)
                            2'd0: begin
                                acc       <= {6'd0, bcd2};
                                conv_step <= 2'd1;
                            end
                            2'd1: begin
                                acc       <= acc_mac;
                                conv_step <= 2'd2;
                            end
                            default: begin
                                acc       <= acc_mac;
                                conv_step <= 2'd0;
                                state     <= DONE;
                                valid     <= 1'b1;
                                if (acc_mac > 10'd255) begin
                                    ovf     <= 1'b1;
                                    bin_out <= '0;
                                end else begin
                                    ovf     <= 1'b0;
                                    bin_out <= neg ? 9'(-{1'b0, acc_mac[7:0]}) : {1'b0, acc_mac[7:0]};
                                end
                            end
                        endcase
                    end
                    DONE: begin
                        state <= ENTRY;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= ENTRY;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
